// File: rtl/j1708_rx_forward_ctrl_if.sv
// Receive-queue and UART-transmit handshake bundle for the J1708 forwarding controller.
// The master side is the controller; the slave side is the receive path plus the UART.
interface j1708_rx_forward_ctrl_if;
    logic       rx_len_exist;
    logic       rx_len_read;
    logic [7:0] rx_len;
    logic       rx_len_valid;
    logic       rx_new_byte;
    logic       rx_byte_read;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       uart_tx_busy;
    logic [7:0] uart_tx_data;
    logic       uart_tx_wr;

    modport master (
        input  rx_len_exist, rx_len, rx_len_valid,
        input  rx_new_byte, rx_byte, rx_byte_valid,
        input  uart_tx_busy,
        output rx_len_read, rx_byte_read, uart_tx_data, uart_tx_wr
    );

    modport slave (
        output rx_len_exist, rx_len, rx_len_valid,
        output rx_new_byte, rx_byte, rx_byte_valid,
        output uart_tx_busy,
        input  rx_len_read, rx_byte_read, uart_tx_data, uart_tx_wr
    );
endinterface

// File: rtl/j1708_rx_forward_ctrl.sv
// Forwards queued J1708 messages to the MCU UART as SYNC/LEN/payload/checksum frames,
// dropping illegal lengths and aborting on stalled responses or enable loss.
module j1708_rx_forward_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'h7E,
    parameter int         MAX_LEN      = 21,
    parameter int         BYTE_TIMEOUT = 26000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    j1708_rx_forward_ctrl_if.master        bus,
    output logic                           frame_active,
    output logic                           frame_done,
    output logic                           err_len,
    output logic                           err_timeout
);

    localparam logic [7:0]  MAX_LEN_B = MAX_LEN[7:0];
    localparam logic [19:0] TMO_LIMIT = BYTE_TIMEOUT[19:0];

    typedef enum logic [3:0] {
        IDLE, LEN_REQ, LEN_WAIT, TX_SYNC, TX_LEN, BYTE_REQ,
        BYTE_WAIT, TX_BYTE, TX_CSUM, DRAIN_REQ, DRAIN_WAIT
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  len_reg, len_next;
    logic [7:0]  count_reg, count_next;
    logic [7:0]  sum_reg, sum_next;
    logic [7:0]  byte_reg, byte_next;
    logic [19:0] tmo_reg, tmo_next;
    logic        guard_reg, guard_next;
    logic        done_reg, done_next;

    logic        timed;
    logic        tx_state;
    logic        abort;
    logic        wr_ok;
    logic        progress;
    logic        tmo_hit;
    logic        len_bad;
    logic [7:0]  csum;
    logic [7:0]  tx_value;

    assign timed    = (state_reg == LEN_WAIT)  || (state_reg == BYTE_REQ) ||
                      (state_reg == BYTE_WAIT) || (state_reg == DRAIN_REQ) ||
                      (state_reg == DRAIN_WAIT);
    assign tx_state = (state_reg == TX_SYNC) || (state_reg == TX_LEN) ||
                      (state_reg == TX_BYTE) || (state_reg == TX_CSUM);
    assign abort    = !enable && (state_reg != IDLE);
    // The cycle right after a write ignores busy: the UART raises it one cycle late.
    assign wr_ok    = tx_state && !bus.uart_tx_busy && !guard_reg;
    assign len_bad  = (bus.rx_len == 8'd0) || (bus.rx_len > MAX_LEN_B);
    assign csum     = ~sum_reg + 8'd1;

    always_comb begin
        progress = 1'b0;
        case (state_reg)
            LEN_WAIT:              progress = bus.rx_len_valid;
            BYTE_REQ, DRAIN_REQ:   progress = bus.rx_new_byte;
            BYTE_WAIT, DRAIN_WAIT: progress = bus.rx_byte_valid;
            default:               progress = 1'b0;
        endcase
    end

    // A response arriving in the expiry cycle beats the timeout.
    assign tmo_hit = timed && (tmo_reg == TMO_LIMIT) && !progress;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            len_reg   <= 8'd0;
            count_reg <= 8'd0;
            sum_reg   <= 8'd0;
            byte_reg  <= 8'd0;
            tmo_reg   <= 20'd0;
            guard_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            count_reg <= count_next;
            sum_reg   <= sum_next;
            byte_reg  <= byte_next;
            tmo_reg   <= tmo_next;
            guard_reg <= guard_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:       if (enable && bus.rx_len_exist) state_next = LEN_REQ;
                LEN_REQ:    state_next = LEN_WAIT;
                LEN_WAIT: begin
                    if (bus.rx_len_valid) begin
                        if (bus.rx_len == 8'd0)          state_next = IDLE;
                        else if (bus.rx_len > MAX_LEN_B) state_next = DRAIN_REQ;
                        else                             state_next = TX_SYNC;
                    end else if (tmo_hit) begin
                        state_next = IDLE;
                    end
                end
                TX_SYNC:    if (wr_ok) state_next = TX_LEN;
                TX_LEN:     if (wr_ok) state_next = BYTE_REQ;
                BYTE_REQ: begin
                    if (bus.rx_new_byte) state_next = BYTE_WAIT;
                    else if (tmo_hit)    state_next = IDLE;
                end
                BYTE_WAIT: begin
                    if (bus.rx_byte_valid) state_next = TX_BYTE;
                    else if (tmo_hit)      state_next = IDLE;
                end
                TX_BYTE: begin
                    if (wr_ok) state_next = (count_reg != 8'd0) ? BYTE_REQ : TX_CSUM;
                end
                TX_CSUM:    if (wr_ok) state_next = IDLE;
                DRAIN_REQ: begin
                    if (bus.rx_new_byte) state_next = DRAIN_WAIT;
                    else if (tmo_hit)    state_next = IDLE;
                end
                DRAIN_WAIT: begin
                    if (bus.rx_byte_valid) state_next = (count_reg == 8'd1) ? IDLE : DRAIN_REQ;
                    else if (tmo_hit)      state_next = IDLE;
                end
                default:    state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        tx_value = 8'h00;
        case (state_reg)
            TX_SYNC: tx_value = SYNC_BYTE;
            TX_LEN:  tx_value = len_reg;
            TX_BYTE: tx_value = byte_reg;
            TX_CSUM: tx_value = csum;
            default: tx_value = 8'h00;
        endcase

        // A write already qualified this cycle completes even when enable drops.
        bus.uart_tx_wr   = wr_ok;
        bus.uart_tx_data = wr_ok ? tx_value : 8'h00;
        bus.rx_len_read  = (state_reg == LEN_REQ) && !abort;
        bus.rx_byte_read = ((state_reg == BYTE_REQ) || (state_reg == DRAIN_REQ)) &&
                           bus.rx_new_byte && !abort;
        err_len          = (state_reg == LEN_WAIT) && bus.rx_len_valid && len_bad && !abort;
        err_timeout      = abort || tmo_hit;
        frame_active     = (state_reg != IDLE);
        frame_done       = done_reg;
    end

    always_comb begin
        len_next   = len_reg;
        count_next = count_reg;
        sum_next   = sum_reg;
        byte_next  = byte_reg;
        guard_next = wr_ok;
        done_next  = (state_reg == TX_CSUM) && wr_ok && !abort;

        if (!abort) begin
            case (state_reg)
                LEN_WAIT: begin
                    if (bus.rx_len_valid) begin
                        len_next   = bus.rx_len;
                        count_next = bus.rx_len;
                        sum_next   = 8'd0;
                    end
                end
                BYTE_WAIT: begin
                    if (bus.rx_byte_valid) begin
                        byte_next  = bus.rx_byte;
                        sum_next   = sum_reg + bus.rx_byte;
                        count_next = count_reg - 8'd1;
                    end
                end
                DRAIN_WAIT: begin
                    if (bus.rx_byte_valid) count_next = count_reg - 8'd1;
                end
                default: ;
            endcase
        end

        if (state_next != state_reg)
            tmo_next = 20'd0;
        else if (timed && (tmo_reg != TMO_LIMIT))
            tmo_next = tmo_reg + 20'd1;
        else
            tmo_next = tmo_reg;
    end

endmodule
